// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver on an oversampled baud tick, with a one-entry valid/ready holding register.
// Optional feature macro UART_RX_MAJORITY_EN: decision sample is the 2-of-3 majority of recent synced samples.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  done_q;

    logic                  sync_meta;
    logic                  sync_q;
    logic                  prev_q;
    logic                  decision;

    // Two-flop synchronizer plus the previous tick's sample for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
            prev_q    <= 1'b1;
        end else begin
            sync_meta <= rx_serial;
            sync_q    <= sync_meta;
            if (baud_tick) begin
                prev_q <= sync_q;
            end
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // The two older samples; together with sync_q they form the three-sample window.
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else if (baud_tick) begin
            hist_q <= {hist_q[0], sync_q};
        end
    end

    assign decision = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync_q) | (hist_q[0] & sync_q);
`else
    assign decision = sync_q;
`endif

    // Frame FSM: start validation at mid start bit, then one sample per bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            frame_err <= 1'b0;
            if (baud_tick) begin
                unique case (state)
                    IDLE: begin
                        if (prev_q && !sync_q) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == HALF_LAST) begin
                            if (decision) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    DATA: begin
                        if (tick_cnt == FULL_LAST) begin
                            shift_q  <= {decision, shift_q[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    STOP: begin
                        if (tick_cnt == FULL_LAST) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            tick_cnt <= '0;
                            if (decision) begin
                                done_q <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Holding register: a completed frame loads one clk after the stop sample if there is room.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (done_q && (!rx_valid || rx_ready)) begin
            rx_data  <= shift_q;
            rx_valid <= 1'b1;
        end else begin
            if (done_q) begin
                overrun <= 1'b1;
            end
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that sits directly upstream of the byte-consuming logic and is the receive counterpart of uart_tx. It samples rx_serial using the 8x-oversampled baud_tick from the RX baud_generator (BAUD_DIV 651 at 50 MHz / 9600 baud). It reassembles 8N1 frames, LSB first, and presents each byte on a valid/ready handshake with a one-entry holding register. It also reports framing errors and overruns.

Parameters:
OVERSAMPLE, 8, baud_tick pulses per bit period; must be even and at least 4.
DATA_BITS, 8, data bits per frame; rx_data width.

Ports:
clk  input  1  system clock; only clock in the block.
rst  input  1  synchronous, active-high reset.
baud_tick  input  1  one-clk-wide pulse at OVERSAMPLE x baud rate.
rx_serial  input  1  asynchronous serial line; idles high.
rx_data  output  DATA_BITS  received byte; stable while rx_valid=1.
rx_valid  output  1  byte available in holding register.
rx_ready  input  1  consumer accepts the byte on a clk edge where rx_valid & rx_ready.
frame_err  output  1  one-clk pulse when the stop bit samples 0.
overrun  output  1  sticky; a completed frame was dropped because the holding register was full.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, tick_cnt=0, bit_cnt=0. Synchronizer flops and previous-sample flop reset to 1.
- rx_serial passes through a 2-flop synchronizer. All sampling below uses the synchronized value, taken only on clk edges where baud_tick=1.
- The "decision sample" is the current synced sample (see Optional Feature for the alternative).
- IDLE: on a baud_tick where the previous sample=1 and the current sample=0 (falling edge), go to START with tick_cnt=0. A line that is held low never triggers a start.
- START: each tick increments tick_cnt. On the tick where tick_cnt==OVERSAMPLE/2-1:
  - decision=1 -> false start, return to IDLE, no outputs change.
  - decision=0 -> go to DATA with tick_cnt=0, bit_cnt=0.
- DATA: on the tick where tick_cnt==OVERSAMPLE-1, shift the decision into the shift register LSB-first, set tick_cnt=0, and increment bit_cnt. All other ticks just increment tick_cnt. After bit DATA_BITS-1, go to STOP.
- STOP: on the tick where tick_cnt==OVERSAMPLE-1, go to IDLE and:
  - decision=1 -> frame complete.
  - decision=0 -> frame_err=1 for exactly one clk; byte discarded; rx_valid and rx_data unchanged.
- Frame complete:
  - If rx_valid=0, or rx_valid & rx_ready in the same clk: load rx_data and set rx_valid=1 on the next clk edge (registered, 1 clk after the stop-sampling tick).
  - Otherwise: new byte dropped, rx_data keeps the old byte, overrun set to 1. overrun stays set until rst.
- Handshake: rx_valid clears on the clk edge where rx_valid & rx_ready, unless a new byte loads in the same edge, in which case rx_valid stays 1 with the new rx_data.
- Counters wrap only by explicit clear. tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS+1) bits.
- rst asserted mid-frame aborts the frame: no frame_err, no valid. The next frame requires a fresh falling edge.
- baud_tick asserted in consecutive clks is legal; each pulse counts.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: a 3-bit history of the last three synced samples is updated on every baud_tick. The decision sample is the majority of this history, applied to start validation, data bits, and stop bit. Falling-edge detection in IDLE still uses raw synced samples. No change to timing or latency.
- Undefined: decision = current synced sample; no history register exists.

Test Plan:
- Bench drives baud_tick every 4 clks, OVERSAMPLE=8, rx_ready=1. Send frame 0x41 (bits per period: 0,1,0,0,0,0,0,1,0,1) -> rx_valid pulses 1 clk with rx_data=0x41; frame_err=0, overrun=0; busy low after stop.
- Line low for 2 ticks, then high -> false start: busy high then back to 0 within 4 ticks; no rx_valid, no frame_err.
- Frame 0x55 with stop bit driven 0 -> frame_err high exactly 1 clk; rx_valid stays 0; rx_data unchanged.
- rx_ready=0, send 0xA5 then 0x3C -> rx_valid=1, rx_data=0xA5 held, overrun=1 after second stop. Raise rx_ready -> rx_valid drops after 1 clk; overrun stays 1 until rst.
- Back-to-back frames 0x00 and 0xFF, with rx_ready pulsed exactly on the clk the second byte loads -> rx_valid remains 1, rx_data=0xFF, overrun=0.
- Assert rst for 1 clk during bit 3 of 0x81, then send 0x81 cleanly -> only one rx_valid, rx_data=0x81. With UART_RX_MAJORITY_EN: a 1-tick low glitch at the mid-sample of bit 0 of 0xFF -> rx_data=0xFF. Without the macro, the same stimulus -> rx_data=0xFE.
